// File: rtl/note_tone_gen.sv
// note_tone_gen: square-wave buzzer driver for the piano controller note bus.
// Latency: inputs sampled at edge N+1; new pitch appears on speaker from edge N+2.
// Backpressure: none; inputs are level-sampled every clock and outputs free-run.
//
// Ports:
//   clk          in  1  system clock, all state on rising edge
//   reset        in  1  asynchronous active-low reset, clears all state at once
//   note_in      in  4  0 = rest, 1..7 = C..B, 8..15 = rest
//   octave_in    in  2  0 = low, 1 = middle, 2 = high, 3 = middle
//   vol_in       in  2  (TONE_VOLUME_EN builds only) 0 = mute, 1..3 = 12.5/25/50% duty
//   speaker      out 1  registered square wave to the buzzer
//   playing      out 1  registered, high while a valid note is sounding
//   period_tick  out 1  registered pulse on the last clock of every full period
//
// Build option: define TONE_VOLUME_EN to add vol_in and duty-cycle volume control.
// Without it the waveform is a fixed 50% duty square wave.

module note_tone_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
`ifdef TONE_VOLUME_EN
  input  logic [1:0] vol_in,
`endif
  output logic       speaker,
  output logic       playing,
  output logic       period_tick
);

  // Middle-octave half periods in clocks, truncated.
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CLK_HZ / (2 * 262));
  localparam logic [CNT_W-1:0] HALF_D = CNT_W'(CLK_HZ / (2 * 294));
  localparam logic [CNT_W-1:0] HALF_E = CNT_W'(CLK_HZ / (2 * 330));
  localparam logic [CNT_W-1:0] HALF_F = CNT_W'(CLK_HZ / (2 * 349));
  localparam logic [CNT_W-1:0] HALF_G = CNT_W'(CLK_HZ / (2 * 392));
  localparam logic [CNT_W-1:0] HALF_A = CNT_W'(CLK_HZ / (2 * 440));
  localparam logic [CNT_W-1:0] HALF_B = CNT_W'(CLK_HZ / (2 * 494));

  typedef enum logic {
    ST_REST = 1'b0,
    ST_TONE = 1'b1
  } state_t;

  // Input stage
  logic [3:0]       r_note_q;
  logic [1:0]       r_oct_q;
`ifdef TONE_VOLUME_EN
  logic [1:0]       r_vol_q;
`endif
  // {note,octave} seen on the previous cycle; a difference while sounding
  // means the player picked a new pitch and the waveform restarts.
  logic [5:0]       r_key;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_speaker;
  logic             r_playing;
  logic             r_tick;
  logic             w_speaker_nxt;
  logic             w_playing_nxt;
  logic             w_tick_nxt;

  logic             w_valid;
  logic             w_change;
  logic [CNT_W-1:0] w_base_half;
  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_last_cnt;
  logic [CNT_W-1:0] w_high;

  assign w_valid    = (r_note_q[3] == 1'b0) && (r_note_q[2:0] != 3'd0);
  assign w_change   = (r_key != {r_note_q, r_oct_q});
  assign w_period   = w_half << 1;
  assign w_last_cnt = w_period - CNT_W'(1);

  // Pitch lookup from the registered note.
  always_comb begin
    w_base_half = '0;
    case (r_note_q[2:0])
      3'd1:    w_base_half = HALF_C;
      3'd2:    w_base_half = HALF_D;
      3'd3:    w_base_half = HALF_E;
      3'd4:    w_base_half = HALF_F;
      3'd5:    w_base_half = HALF_G;
      3'd6:    w_base_half = HALF_A;
      3'd7:    w_base_half = HALF_B;
      default: w_base_half = '0;
    endcase
  end

  // Octave scaling; code 3 is an alias for the middle octave.
  always_comb begin
    w_half = w_base_half;
    case (r_oct_q)
      2'd0:    w_half = w_base_half << 1;
      2'd2:    w_half = w_base_half >> 1;
      default: w_half = w_base_half;
    endcase
  end

  // High-phase length. Volume only reshapes the duty cycle; the period and
  // counter are untouched so a volume change never restarts the waveform.
`ifdef TONE_VOLUME_EN
  always_comb begin
    w_high = '0;
    case (r_vol_q)
      2'd1:    w_high = w_period >> 3;
      2'd2:    w_high = w_period >> 2;
      2'd3:    w_high = w_period >> 1;
      default: w_high = '0;
    endcase
  end
`else
  assign w_high = w_half;
`endif

  // Next-state and next-output logic. Outputs are computed from the counter
  // value being loaded, so speaker/period_tick line up with r_cnt exactly.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = '0;
    w_speaker_nxt = 1'b0;
    w_playing_nxt = 1'b0;
    w_tick_nxt    = 1'b0;

    case (r_state)
      ST_REST: begin
        if (w_valid) begin
          w_state_nxt = ST_TONE;
          w_cnt_nxt   = '0;
        end
      end
      ST_TONE: begin
        if (!w_valid) begin
          // Cut period: the tick below stays low because the state leaves TONE.
          w_state_nxt = ST_REST;
        end else if (w_change) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == w_last_cnt) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_REST;
    endcase

    if (w_state_nxt == ST_TONE) begin
      w_playing_nxt = 1'b1;
      w_speaker_nxt = (w_cnt_nxt < w_high);
      w_tick_nxt    = (w_cnt_nxt == w_last_cnt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_note_q  <= 4'd0;
      r_oct_q   <= 2'd1;
`ifdef TONE_VOLUME_EN
      r_vol_q   <= 2'd0;
`endif
      r_key     <= 6'd0;
      r_state   <= ST_REST;
      r_cnt     <= '0;
      r_speaker <= 1'b0;
      r_playing <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_note_q  <= note_in;
      r_oct_q   <= octave_in;
`ifdef TONE_VOLUME_EN
      r_vol_q   <= vol_in;
`endif
      r_key     <= {r_note_q, r_oct_q};
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_speaker <= w_speaker_nxt;
      r_playing <= w_playing_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign speaker     = r_speaker;
  assign playing     = r_playing;
  assign period_tick = r_tick;

endmodule
